// File: rtl/display_pkg.sv
// display_pkg: frame geometry, colour type and clear FSM states shared by the display blocks.
package display_pkg;
  localparam int COLOR_CHANNEL_DEPTH = 2;
  localparam int SCREEN_WIDTH = 160;
  localparam int SCREEN_HEIGHT = 120;
  typedef logic [3*COLOR_CHANNEL_DEPTH-1:0] colour_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} clear_state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: row-major (x,y) walk over the frame, holding at the final pixel.
module raster_counter #(
  parameter int SCREEN_WIDTH = display_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = display_pkg::SCREEN_HEIGHT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);
  logic x_end;
  assign x_end = x == 8'(SCREEN_WIDTH - 1);
  assign last = x_end && y == 7'(SCREEN_HEIGHT - 1);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last) begin
      x <= x_end ? '0 : x + 8'd1;
      y <= x_end ? y + 7'd1 : y;
    end
endmodule

// File: rtl/clear_screen.sv
// clear_screen: fills the frame buffer with bg_color one pixel per clock for the sequencer's clear phase.
module clear_screen #(
  parameter int COLOR_CHANNEL_DEPTH = display_pkg::COLOR_CHANNEL_DEPTH,
  parameter int SCREEN_WIDTH = display_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = display_pkg::SCREEN_HEIGHT
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             enable,
  input  logic [3*COLOR_CHANNEL_DEPTH-1:0] bg_color,
  input  logic                             pause,
  output logic                             done,
  output logic [7:0]                       x,
  output logic [6:0]                       y,
  output logic [3*COLOR_CHANNEL_DEPTH-1:0] colour,
  output logic                             writeEn
);
  import display_pkg::*;
  logic [1:0] state;
  logic       last, clear, advance;
  if (SCREEN_WIDTH > 256 || SCREEN_HEIGHT > 128 || SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1) begin : g_bad_size
    $error("clear_screen: frame %0dx%0d exceeds 8-bit x / 7-bit y counters", SCREEN_WIDTH, SCREEN_HEIGHT);
  end
  assign clear = state == IDLE ? enable : !(state inside {SWEEP, DONE});
  // A pixel presented with writeEn high is consumed on this edge, so move on even if pause arrives now.
  assign advance = state == SWEEP && enable && writeEn && !last;
  raster_counter #(.SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)) u_raster (
    .clock(clock), .resetn(resetn), .clear(clear), .advance(advance), .x(x), .y(y), .last(last)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      done <= 1'b0;
      writeEn <= 1'b0;
      colour <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          writeEn <= enable;
          if (enable) begin
            state <= SWEEP;
            colour <= bg_color;
          end
        end
        SWEEP:
          if (!enable) begin
            state <= IDLE;
            writeEn <= 1'b0;
          end else if (writeEn && last) begin
            state <= DONE;
            writeEn <= 1'b0;
            done <= 1'b1;
          end else writeEn <= !pause;
        DONE: begin
          writeEn <= 1'b0;
          done <= enable;
          if (!enable) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          writeEn <= 1'b0;
          done <= 1'b0;
          colour <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_clear_screen.sv
// tb_clear_screen: directed checks of clear_screen on a 4x3 frame plus one full 160x120 sweep.
module tb_clear_screen;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic resetn, enable, pause, done, writeEn;
  logic [5:0] bg_color, colour;
  logic [7:0] x;
  logic [6:0] y;
  logic en_d, done_d, we_d;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [5:0] col_d;
  clear_screen #(.COLOR_CHANNEL_DEPTH(2), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(3)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .bg_color(bg_color), .pause(pause),
    .done(done), .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );
  clear_screen dut_full (
    .clock(clock), .resetn(resetn), .enable(en_d), .bg_color(6'b010101), .pause(1'b0),
    .done(done_d), .x(x_d), .y(y_d), .colour(col_d), .writeEn(we_d)
  );
  int passed = 0, total = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  typedef struct {
    logic       en;
    logic [5:0] bg;
    logic       we;
    logic [7:0] x;
    logic [6:0] y;
    logic       done;
    logic       xy;
  } vec_t;
  vec_t tbl[15];
  initial begin
    int cyc, writes, dup, oob, idx, lx, ly;
    logic [11:0] seen;
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b1, i < 5 ? 6'b110000 : 6'b001111, 1'b1, 8'(i % 4), 7'(i / 4), 1'b0, 1'b1};
    tbl[12] = '{1'b1, 6'b001111, 1'b0, 8'd3, 7'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 6'b001111, 1'b0, 8'd3, 7'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 6'b001111, 1'b0, 8'd0, 7'd0, 1'b0, 1'b0};
    resetn = 1'b0; enable = 1'b0; pause = 1'b0; bg_color = '0; en_d = 1'b0;
    #12;
    check("reset.we", writeEn, 0);
    check("reset.done", done, 0);
    check("reset.x", x, 0);
    check("reset.y", y, 0);
    check("reset.colour", colour, 0);
    check("reset_full.we", we_d, 0);
    resetn = 1'b1;
    tick;
    check("idle.we", writeEn, 0);
    // full 4x3 sweep; bg change from row 5 on must not reach colour
    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en;
      bg_color = tbl[i].bg;
      tick;
      check($sformatf("sweep%0d.we", i), writeEn, tbl[i].we);
      check($sformatf("sweep%0d.done", i), done, tbl[i].done);
      if (tbl[i].xy) begin
        check($sformatf("sweep%0d.x", i), x, tbl[i].x);
        check($sformatf("sweep%0d.y", i), y, tbl[i].y);
        check($sformatf("sweep%0d.colour", i), colour, 6'b110000);
      end
    end
    // pause for 3 cycles while (1,1) is being written; (2,1) held
    enable = 1'b1; bg_color = 6'b000011;
    writes = 0; dup = 0; oob = 0; seen = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      pause = k >= 6 && k <= 8;
      tick;
      if (k >= 6 && k <= 9) begin
        check($sformatf("pause%0d.we", k), writeEn, k == 9);
        check($sformatf("pause%0d.x", k), x, 2);
        check($sformatf("pause%0d.y", k), y, 1);
      end
      if (writeEn) begin
        idx = int'(y) * 4 + int'(x);
        writes++;
        if (x > 3 || idx > 11) oob++;
        else begin
          if (seen[idx]) dup++;
          seen[idx] = 1'b1;
        end
      end
    end
    pause = 1'b0;
    check("pause.done", done, 1);
    check("pause.writes", writes, 12);
    check("pause.dup", dup, 0);
    check("pause.oob", oob, 0);
    check("pause.coverage", seen, 12'hfff);
    enable = 1'b0;
    tick;
    check("pause.release_done", done, 0);
    // abort after 5 writes, then restart with a new colour
    enable = 1'b1; bg_color = 6'b000011;
    writes = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (writeEn) writes++;
    end
    check("abort.writes", writes, 5);
    enable = 1'b0;
    tick;
    check("abort.we", writeEn, 0);
    check("abort.done", done, 0);
    bg_color = 6'b101010; enable = 1'b1;
    tick;
    check("restart.we", writeEn, 1);
    check("restart.x", x, 0);
    check("restart.y", y, 0);
    check("restart.colour", colour, 6'b101010);
    enable = 1'b0;
    tick;
    // asynchronous reset at (1,2)
    enable = 1'b1; bg_color = 6'b111111;
    for (int k = 0; k < 10; k++) tick;
    check("areset.pre_x", x, 1);
    check("areset.pre_y", y, 2);
    #2 resetn = 1'b0;
    #1;
    check("areset.we", writeEn, 0);
    check("areset.done", done, 0);
    check("areset.x", x, 0);
    check("areset.y", y, 0);
    check("areset.colour", colour, 0);
    tick;
    #2 resetn = 1'b1;
    tick;
    check("areset.restart_we", writeEn, 1);
    check("areset.restart_x", x, 0);
    check("areset.restart_y", y, 0);
    check("areset.restart_colour", colour, 6'b111111);
    enable = 1'b0;
    tick;
    // sequencer handshake: drop enable the cycle after done is seen
    enable = 1'b1; bg_color = 6'b000001;
    cyc = 0;
    while (!done && cyc < 20) begin
      tick;
      cyc++;
    end
    check("hs.done_cycle", cyc, 13);
    enable = 1'b0;
    tick;
    check("hs.done_drop", done, 0);
    check("hs.we_drop", writeEn, 0);
    writes = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (writeEn || done) writes++;
    end
    check("hs.no_resweep", writes, 0);
    // default geometry: 19200 writes, last at (159,119), done on cycle 19201
    en_d = 1'b1;
    writes = 0; oob = 0; cyc = 0; lx = -1; ly = -1;
    for (int c = 1; c <= 19300 && cyc == 0; c++) begin
      tick;
      if (we_d) begin
        writes++;
        lx = int'(x_d);
        ly = int'(y_d);
      end
      if (x_d >= 8'd160 || y_d >= 7'd120) oob++;
      if (done_d) cyc = c;
    end
    check("full.writes", writes, 19200);
    check("full.last_x", lx, 159);
    check("full.last_y", ly, 119);
    check("full.oob", oob, 0);
    check("full.done_cycle", cyc, 19201);
    en_d = 1'b0;
    tick;
    check("full.done_drop", done_d, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
